// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips axis-aligned fill commands to the screen and
// streams one framebuffer write per clock, then a done pulse plus an optional flush.
// Latency: accept at edge T -> first write in cycle T+1; done/flush one cycle after the last write.
// Backpressure: o_cmd_ready is high only in IDLE. A valid held during FILL/DONE waits and is not consumed.
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready command handshake; i_x0,i_y0,i_w,i_h,i_color,i_flush_after sampled on accept
//   o_waddr/o_wdata/o_we    framebuffer write port (addr = y*H_RES + x)
//   o_flush, o_done         one-cycle pulses after the command; o_busy = command in progress
module rect_fill_engine #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 3
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [8:0]         i_x0,
  input  logic [7:0]         i_y0,
  input  logic [8:0]         i_w,
  input  logic [7:0]         i_h,
  input  logic [COLOR_W-1:0] i_color,
  input  logic               i_flush_after,
  output logic [ADDR_W-1:0]  o_waddr,
  output logic [COLOR_W-1:0] o_wdata,
  output logic               o_we,
  output logic               o_flush,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [9:0]        H_RES_X = 10'(H_RES);
  localparam logic [8:0]        V_RES_Y = 9'(V_RES);
  localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

  logic [1:0]         state_q, state_d;
  logic [8:0]         x_q, x_d;
  logic [8:0]         x0_q, x0_d;
  logic [9:0]         xlast_q, xlast_d;
  logic [7:0]         y_q, y_d;
  logic [8:0]         ylast_q, ylast_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [COLOR_W-1:0] wdata_q, wdata_d;
  logic               flush_after_q, flush_after_d;
  logic               we_q, we_d;
  logic               done_q, done_d;
  logic               flush_q, flush_d;

  // Command decode, only meaningful in the accept cycle.
  logic [9:0]        sum_x, xe_clip;
  logic [8:0]        sum_y, ye_clip;
  logic              degen;
  logic [ADDR_W-1:0] y_base;
  logic              last_col, last_row;

  always_comb begin
    // Widened sums cannot overflow: 511+511 fits in 10 bits, 255+255 in 9.
    sum_x   = {1'b0, i_x0} + {1'b0, i_w};
    sum_y   = {1'b0, i_y0} + {1'b0, i_h};
    xe_clip = (sum_x > H_RES_X) ? H_RES_X : sum_x;
    ye_clip = (sum_y > V_RES_Y) ? V_RES_Y : sum_y;
    degen   = (i_w == 9'd0) || (i_h == 8'd0) ||
              ({1'b0, i_x0} >= H_RES_X) || ({1'b0, i_y0} >= V_RES_Y);
    // Start-of-command row base only; constant multiplier reduces to shift/add.
    // Subsequent rows step the base by H_RES.
    y_base   = ADDR_W'(i_y0) * H_RES_A;
    last_col = ({1'b0, x_q} == xlast_q);
    last_row = ({1'b0, y_q} == ylast_q);
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    x0_d          = x0_q;
    xlast_d       = xlast_q;
    y_d           = y_q;
    ylast_d       = ylast_q;
    row_base_d    = row_base_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    flush_after_d = flush_after_q;
    we_d          = 1'b0;
    done_d        = 1'b0;
    flush_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          x0_d          = i_x0;
          x_d           = i_x0;
          y_d           = i_y0;
          xlast_d       = xe_clip - 10'd1;
          ylast_d       = ye_clip - 9'd1;
          row_base_d    = y_base;
          flush_after_d = i_flush_after;
          if (degen) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            flush_d = i_flush_after;
          end else begin
            state_d = S_FILL;
            we_d    = 1'b1;
            waddr_d = y_base + ADDR_W'(i_x0);
            wdata_d = i_color;
          end
        end
      end
      S_FILL: begin
        // x_q/y_q name the pixel currently on the write port.
        if (last_col && last_row) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          flush_d = flush_after_q;
        end else if (last_col) begin
          x_d        = x0_q;
          y_d        = y_q + 8'd1;
          row_base_d = row_base_q + H_RES_A;
          waddr_d    = row_base_q + H_RES_A + ADDR_W'(x0_q);
          we_d       = 1'b1;
        end else begin
          x_d     = x_q + 9'd1;
          waddr_d = waddr_q + ADDR_W'(1);
          we_d    = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      x0_q          <= '0;
      xlast_q       <= '0;
      y_q           <= '0;
      ylast_q       <= '0;
      row_base_q    <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      flush_after_q <= 1'b0;
      we_q          <= 1'b0;
      done_q        <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      x0_q          <= x0_d;
      xlast_q       <= xlast_d;
      y_q           <= y_d;
      ylast_q       <= ylast_d;
      row_base_q    <= row_base_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      flush_after_q <= flush_after_d;
      we_q          <= we_d;
      done_q        <= done_d;
      flush_q       <= flush_d;
    end
  end

  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_waddr     = waddr_q;
  assign o_wdata     = wdata_q;
  assign o_we        = we_q;
  assign o_done      = done_q;
  assign o_flush     = flush_q;

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Drawing stage that sits directly upstream of the video controller's framebuffer write port. Accepts axis-aligned rectangle fill commands, clips them to the 320x240 screen, and streams one pixel write per clock (address, colour, write-enable) into the back buffer. Optionally issues a one-cycle flush (buffer swap) request after the last pixel of a command. Full-screen clears and UI box drawing use this block; the controller then displays the result.

## Interface
- H_RES, 320, visible pixels per line
- V_RES, 240, visible lines per frame
- ADDR_W, 17, framebuffer address width (H_RES*V_RES <= 2**ADDR_W)
- COLOR_W, 3, pixel colour width
- i_clk  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  engine idle, command accepted when valid&&ready
- i_x0  in  9  left column
- i_y0  in  8  top line
- i_w  in  9  width in pixels
- i_h  in  8  height in lines
- i_color  in  COLOR_W  fill colour
- i_flush_after  in  1  request buffer swap after this command
- o_waddr  out  ADDR_W  framebuffer write address, y*H_RES+x
- o_wdata  out  COLOR_W  framebuffer write data
- o_we  out  1  write strobe, one pixel per cycle
- o_flush  out  1  one-cycle swap request to video controller
- o_busy  out  1  command in progress (FILL or DONE)
- o_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FILL, DONE. Reset -> IDLE.
- IDLE: o_cmd_ready=1. On valid&&ready latch x0, y0, colour, flush_after; compute clipped bounds xe=min(x0+w, H_RES), ye=min(y0+h, V_RES) (10-bit / 9-bit sums, no overflow). Degenerate if w==0, h==0, x0>=H_RES or y0>=V_RES -> DONE; else -> FILL.
- FILL: each cycle output o_we=1, o_waddr=current address, o_wdata=colour. Raster order: x increments from x0 to xe-1; at row end x reloads x0, y increments, row base address += H_RES (no multiplier; address = row base + x offset, maintained incrementally). After pixel (xe-1, ye-1) -> DONE.
- DONE: one cycle; o_done=1, o_flush=latched flush_after, o_we=0 -> IDLE.
- Inputs other than i_cmd_valid ignored outside IDLE; command fields need only be valid in the accept cycle.
- o_wdata holds last colour when o_we=0; o_waddr value irrelevant when o_we=0 but must be deterministic (holds last).
- Async reset mid-command: outputs forced to reset values immediately, command abandoned, no flush issued.

## Timing
- Reset values: o_cmd_ready=1, o_we=0, o_flush=0, o_busy=0, o_done=0, o_waddr=0, o_wdata=0.
- All outputs registered. Accept at edge T -> first write visible cycle T+1.
- Clipped area N=(xe-x0)*(ye-y0): writes occupy cycles T+1..T+N contiguous, no gaps; o_done/o_flush at T+N+1; o_cmd_ready=1 at T+N+2.
- Degenerate command: o_done (and o_flush if requested) at T+1, ready at T+2.
- o_busy = state != IDLE; o_cmd_ready = !o_busy.
- Throughput: back-to-back commands, one idle cycle between commands; valid held high during busy is not consumed.

## Test plan
- Full clear: (0,0,320,240), colour 3'b001, flush_after=1 -> 76800 writes, addresses 0..76799 in order, o_flush and o_done single pulse at T+76801.
- Small rect: (10,5,4,3), colour 3'b101 -> 12 writes, addrs 1610-1613, 1930-1933, 2250-2253; o_done at T+13, no o_flush.
- Clipping: (318,238,10,10) -> exactly 4 writes, addrs 76478, 76479, 76798, 76799.
- Degenerate: w=0, then x0=320 -> zero writes, o_done at T+1 each; flush_after=1 yields o_flush at T+1.
- Reset mid-fill: assert i_reset_n=0 after 100 writes of full clear -> o_we=0 asynchronously, no o_flush; after release ready=1 and a new (0,0,1,1) command writes addr 0.
- Back-to-back: valid held high with two commands -> second accepted only when ready returns; write stream matches expected addresses, no lost or duplicated pixels.
